// File: rtl/bsg_tag_pkg.sv
// Shared types and default geometry for the bsg_tag serial transmitter.
package bsg_tag_pkg;

    localparam int unsigned bsg_tag_els_gp           = 32;
    localparam int unsigned bsg_tag_lg_width_gp      = 4;
    localparam int unsigned bsg_tag_id_width_gp      = $clog2(bsg_tag_els_gp);
    localparam int unsigned bsg_tag_payload_width_gp = (1 << bsg_tag_lg_width_gp) - 1;

    typedef enum logic [2:0] {
        IDLE,
        RST_BURST,
        START,
        ID,
        DNR,
        LEN,
        PAYLOAD,
        GAP
    } bsg_tag_tx_state_e;

    typedef struct packed {
        logic                                master_reset;
        logic [bsg_tag_id_width_gp-1:0]      node_id;
        logic                                data_not_reset;
        logic [bsg_tag_lg_width_gp-1:0]      len;
        logic [bsg_tag_payload_width_gp-1:0] payload;
    } bsg_tag_tx_req_s;

endpackage

// File: rtl/bsg_tag_tx_shifter.sv
// Loadable LSB-first shift register with a non-wrapping down-counter,
// shared by every multi-bit field of a tag packet.
module bsg_tag_tx_shifter #(
    parameter int unsigned data_width_p = 15,
    parameter int unsigned cnt_width_p  = 7
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    load_i,
    input  logic                    shift_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic [cnt_width_p-1:0]  count_i,
    output logic                    next_bit_c,
    output logic                    done_c
);

    logic [data_width_p-1:0] data_r;
    logic [cnt_width_p-1:0]  cnt_r;

    // Load has priority; shifting stops once the counter reaches zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r <= '0;
            cnt_r  <= '0;
        end else if (load_i) begin
            data_r <= data_i;
            cnt_r  <= count_i;
        end else if (shift_i && (cnt_r != '0)) begin
            data_r <= data_r >> 1;
            cnt_r  <= cnt_r - cnt_width_p'(1);
        end
    end

    assign next_bit_c = data_r[1];
    assign done_c     = (cnt_r == '0);

endmodule

// File: rtl/bsg_tag_serial_tx.sv
// Transmit side of the bsg_tag serial protocol: serialises tag packets and
// master-reset bursts onto the tag data/enable pins with registered outputs.
module bsg_tag_serial_tx
    import bsg_tag_pkg::*;
#(
    parameter  int unsigned els_p            = bsg_tag_els_gp,
    parameter  int unsigned lg_width_p       = bsg_tag_lg_width_gp,
    parameter  int unsigned reset_ones_p     = 64,
    parameter  int unsigned gap_bits_p       = 2,
    localparam int unsigned id_width_lp      = $clog2(els_p),
    localparam int unsigned payload_width_lp = (1 << lg_width_p) - 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic                        master_reset_i,
    input  logic [id_width_lp-1:0]      node_id_i,
    input  logic                        data_not_reset_i,
    input  logic [lg_width_p-1:0]       len_i,
    input  logic [payload_width_lp-1:0] payload_i,
    output logic                        tag_data_o,
    output logic                        tag_en_o,
    output logic                        idle_o
);

    localparam int unsigned cnt_max_lp = (reset_ones_p > (1 << lg_width_p))
                                         ? reset_ones_p : (1 << lg_width_p);
    localparam int unsigned cnt_w_lp   = $clog2(cnt_max_lp + 1);

    bsg_tag_tx_state_e state_r, state_n;
    bsg_tag_tx_req_s   req_r;

    logic                        accept;
    logic                        load, shift;
    logic [payload_width_lp-1:0] ld_data;
    logic [cnt_w_lp-1:0]         ld_cnt;
    logic                        data_n, en_n;
    logic                        next_bit_c, done_c;

    assign accept = v_i & ready_o;

    bsg_tag_tx_shifter #(
        .data_width_p (payload_width_lp),
        .cnt_width_p  (cnt_w_lp)
    ) shifter (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (load),
        .shift_i    (shift),
        .data_i     (ld_data),
        .count_i    (ld_cnt),
        .next_bit_c (next_bit_c),
        .done_c     (done_c)
    );

    // Next state plus the bit that goes on the wire next cycle. Entering a
    // state loads its field and emits bit 0; staying shifts to the next bit.
    always_comb begin
        state_n = state_r;
        shift   = 1'b0;
        ld_data = '0;
        ld_cnt  = '0;
        data_n  = 1'b0;
        en_n    = 1'b0;

        case (state_r)
            IDLE:      if (accept) state_n = master_reset_i ? RST_BURST : START;
            RST_BURST: if (done_c) state_n = GAP;
                       else begin shift = 1'b1; data_n = 1'b1; en_n = 1'b1; end
            START:     if (done_c) state_n = ID;
            ID:        if (done_c) state_n = DNR;
                       else begin shift = 1'b1; data_n = next_bit_c; en_n = 1'b1; end
            DNR:       if (done_c) state_n = LEN;
            LEN:       if (done_c) state_n = (req_r.len != '0) ? PAYLOAD : GAP;
                       else begin shift = 1'b1; data_n = next_bit_c; en_n = 1'b1; end
            PAYLOAD:   if (done_c) state_n = GAP;
                       else begin shift = 1'b1; data_n = next_bit_c; en_n = 1'b1; end
            GAP:       if (done_c) state_n = IDLE;
                       else shift = 1'b1;
            default:   state_n = IDLE;
        endcase

        load = (state_n != state_r);

        if (load) begin
            case (state_n)
                RST_BURST: begin
                    ld_cnt = cnt_w_lp'(reset_ones_p - 1);
                    data_n = 1'b1;
                    en_n   = 1'b1;
                end
                START: begin
                    data_n = 1'b1;
                    en_n   = 1'b1;
                end
                ID: begin
                    ld_data = payload_width_lp'(req_r.node_id);
                    ld_cnt  = cnt_w_lp'(id_width_lp - 1);
                    data_n  = req_r.node_id[0];
                    en_n    = 1'b1;
                end
                DNR: begin
                    data_n = req_r.data_not_reset;
                    en_n   = 1'b1;
                end
                LEN: begin
                    ld_data = payload_width_lp'(req_r.len);
                    ld_cnt  = cnt_w_lp'(lg_width_p - 1);
                    data_n  = req_r.len[0];
                    en_n    = 1'b1;
                end
                PAYLOAD: begin
                    ld_data = req_r.payload;
                    ld_cnt  = cnt_w_lp'(req_r.len) - cnt_w_lp'(1);
                    data_n  = req_r.payload[0];
                    en_n    = 1'b1;
                end
                GAP:       ld_cnt = cnt_w_lp'(gap_bits_p - 1);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            req_r      <= '0;
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
            ready_o    <= 1'b0;
            idle_o     <= 1'b1;
        end else begin
            state_r    <= state_n;
            tag_data_o <= data_n;
            tag_en_o   <= en_n;
            ready_o    <= (state_n == IDLE);
            idle_o     <= (state_n == IDLE);
            if (accept) begin
                req_r <= '{master_reset:   master_reset_i,
                           node_id:        node_id_i,
                           data_not_reset: data_not_reset_i,
                           len:            len_i,
                           payload:        payload_i};
            end
        end
    end

    // Out-of-range ids are sent as-is; flag them in simulation only.
    id_range_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (accept && !master_reset_i) |-> (32'(node_id_i) < els_p))
        else $warning("node_id_i %0d is not below els_p", node_id_i);

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Directed and randomised bench for bsg_tag_serial_tx against a bit-stream model.
module tb_bsg_tag_serial_tx;

    localparam int unsigned ID_W     = 5;
    localparam int unsigned LG_W     = 4;
    localparam int unsigned PL_W     = 15;
    localparam int unsigned RST_ONES = 64;
    localparam int unsigned GAP_BITS = 2;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            v_i;
    logic            ready_o;
    logic            master_reset_i;
    logic [ID_W-1:0] node_id_i;
    logic            data_not_reset_i;
    logic [LG_W-1:0] len_i;
    logic [PL_W-1:0] payload_i;
    logic            tag_data_o;
    logic            tag_en_o;
    logic            idle_o;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit mr;
        int id;
        bit dnr;
        int len;
        int payload;
    } req_t;

    typedef struct {
        bit en;
        bit dat;
        bit rdy;
    } cyc_t;

    cyc_t exp_q[$];

    bsg_tag_serial_tx dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .v_i              (v_i),
        .ready_o          (ready_o),
        .master_reset_i   (master_reset_i),
        .node_id_i        (node_id_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .tag_data_o       (tag_data_o),
        .tag_en_o         (tag_en_o),
        .idle_o           (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int idx, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp_v);
        end
    endtask

    function automatic void push(input bit en, input bit dat, input bit rdy);
        cyc_t c;
        c.en  = en;
        c.dat = dat;
        c.rdy = rdy;
        exp_q.push_back(c);
    endfunction

    // Expected wire activity per cycle after acceptance: bits, gap, one idle cycle.
    function automatic void model(input req_t r);
        if (r.mr) begin
            for (int i = 0; i < int'(RST_ONES); i++) push(1'b1, 1'b1, 1'b0);
        end else begin
            push(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < int'(ID_W); i++) push(1'b1, 1'((r.id >> i) & 1), 1'b0);
            push(1'b1, r.dnr, 1'b0);
            for (int i = 0; i < int'(LG_W); i++) push(1'b1, 1'((r.len >> i) & 1), 1'b0);
            for (int i = 0; i < r.len; i++) push(1'b1, 1'((r.payload >> i) & 1), 1'b0);
        end
        for (int g = 0; g < int'(GAP_BITS); g++) push(1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1);
    endfunction

    task automatic drive(input req_t r);
        master_reset_i   = r.mr;
        node_id_i        = ID_W'(r.id);
        data_not_reset_i = r.dnr;
        len_i            = LG_W'(r.len);
        payload_i        = PL_W'(r.payload);
        v_i              = 1'b1;
    endtask

    task automatic scramble();
        master_reset_i   = 1'($urandom_range(0, 1));
        node_id_i        = ID_W'($urandom);
        data_not_reset_i = 1'($urandom_range(0, 1));
        len_i            = LG_W'($urandom);
        payload_i        = PL_W'($urandom);
    endtask

    task automatic run_stream(input string tag, input int limit);
        cyc_t c;
        int   k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            c = exp_q.pop_front();
            @(negedge clk_i);
            check({tag, "_en"},    k, tag_en_o,   c.en);
            check({tag, "_data"},  k, tag_data_o, c.dat);
            check({tag, "_ready"}, k, ready_o,    c.rdy);
            check({tag, "_idle"},  k, idle_o,     c.rdy);
            k++;
        end
        exp_q.delete();
    endtask

    // Called on a negedge in IDLE; returns on the negedge of the idle cycle.
    task automatic send(input req_t r, input string tag);
        check({tag, "_ready_at_issue"}, 0, ready_o, 1'b1);
        drive(r);
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        scramble();
        model(r);
        run_stream(tag, 1000);
    endtask

    function automatic req_t mk(input bit mr, input int id, input bit dnr, input int len, input int pl);
        req_t r;
        r.mr = mr; r.id = id; r.dnr = dnr; r.len = len; r.payload = pl;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(1'b0, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 32767)));
    endfunction

    initial begin
        req_t r1, r2;

        reset_n_i = 1'b0;
        v_i       = 1'b0;
        scramble();

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk_i);
        check("rst_en",    0, tag_en_o,   1'b0);
        check("rst_data",  0, tag_data_o, 1'b0);
        check("rst_ready", 0, ready_o,    1'b0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("rel_en",    0, tag_en_o,   1'b0);
        check("rel_data",  0, tag_data_o, 1'b0);
        check("rel_ready", 0, ready_o,    1'b1);
        check("rel_idle",  0, idle_o,     1'b1);

        send(mk(1'b1, 0, 1'b0, 0, 0), "burst");
        send(mk(1'b0, 5, 1'b1, 3, 15'b110), "pkt5");
        send(mk(1'b0, 31, 1'b0, 0, int'($urandom_range(0, 32767))), "zlen");
        send(mk(1'b0, 0, 1'b1, 15, 32767), "maxlen");

        for (int i = 0; i < 6; i++) send(rand_req(), "rand");

        // Back-to-back: second request held valid through the first transfer.
        r1 = rand_req();
        r1.len = 1 + int'($urandom_range(0, 14));
        r2 = rand_req();
        check("b2b_ready_at_issue", 0, ready_o, 1'b1);
        drive(r1);
        @(posedge clk_i);
        #1;
        drive(r2);
        model(r1);
        run_stream("b2b_first", 1000);
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        scramble();
        model(r2);
        run_stream("b2b_second", 1000);

        // Asynchronous reset in the middle of a payload.
        r1 = mk(1'b0, 9, 1'b1, 15, int'($urandom_range(0, 32767)));
        drive(r1);
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        scramble();
        model(r1);
        run_stream("mid", 1 + int'(ID_W) + 1 + int'(LG_W) + 3);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_en",    0, tag_en_o,   1'b0);
        check("mid_rst_data",  0, tag_data_o, 1'b0);
        check("mid_rst_ready", 0, ready_o,    1'b0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("mid_rel_ready", 0, ready_o,  1'b1);
        check("mid_rel_idle",  0, idle_o,   1'b1);
        check("mid_rel_en",    0, tag_en_o, 1'b0);
        send(mk(1'b1, 0, 1'b0, 0, 0), "rec_burst");
        send(rand_req(), "rec_pkt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
